jpeg_bit_packer: RTL
====================

// Module: jpeg_bit_packer
// PURPOSE
//  Packs variable-length entropy-coder codewords, MSB-first, into a JPEG scan byte stream.
//  Inserts 0x00 after every 0xFF data byte (byte stuffing).
//  On end of scan: pads the final partial byte with 1s, then marks the final byte.
//  Sits directly upstream of the AXI-Stream master stage; drives its data/valid/end inputs and obeys its wait.
// PARAMETERS
//  MAX_CODE_LEN  32  widest codeword accepted per beat, in bits (legal range 8..32)
//  BUF_W         64  bit-accumulator width; must be >= MAX_CODE_LEN+8
// PORTS
//  clk         in   1                            single clock; all logic on posedge
//  rst         in   1                            synchronous, active-high reset
//  i_code      in   MAX_CODE_LEN                 codeword, right-aligned; bits above i_len ignored
//  i_len       in   $clog2(MAX_CODE_LEN+1)       codeword length 0..MAX_CODE_LEN; larger values saturate
//  i_valid     in   1                            codeword present
//  i_last      in   1                            with i_valid: final codeword of the scan
//  o_ready     out  1                            codeword accepted when i_valid & o_ready
//  o_data      out  8                            output byte
//  o_valid     out  1                            byte transferred this cycle (already gated by i_wait)
//  o_data_end  out  1                            with o_valid: last byte of the scan
//  i_wait      in   1                            downstream full; no byte may transfer while high
// BEHAVIOUR
//  Reset: state=RUN, fill=0, last_seen=0.
//   o_valid=0, o_data_end=0, o_data=0, o_ready=1 the cycle after rst drops.
//  Accumulator
//   - Codewords are appended below existing bits.
//   - Output byte = top 8 valid bits.
//   - fill' = fill + len_accepted - 8*byte_popped; accept and pop may occur in the same cycle.
//  o_ready = (state==RUN) & !last_seen & (fill <= BUF_W-MAX_CODE_LEN); decided on current fill.
//  o_valid is combinational: byte_pending & !i_wait. All other outputs are registered or state-decoded.
//  States:
//   RUN   - Pop a byte whenever fill>=8 and !i_wait.
//           - Popped 0xFF -> STUFF.
//           - last_seen & fill<8 -> PAD if fill>0.
//           - last_seen & fill==0 -> EOI_FF if enabled, else RUN with last_seen cleared.
//   STUFF - Emit 0x00 (waits while i_wait); then back to RUN.
//   PAD   - Emit {remaining bits, 1s}.
//           - Result 0xFF -> STUFF_END.
//           - Otherwise -> EOI_FF / RUN.
//   STUFF_END - Emit 0x00; then -> EOI_FF / RUN.
//   EOI_FF, EOI_D9 - Emit the marker bytes unstuffed; then RUN with last_seen cleared.
//  o_data_end rule: asserted on exactly one byte per scan.
//   - With EOI enabled: the 0xD9.
//   - Otherwise: the final pad byte, its stuffed 0x00, or the last whole byte / its stuffed 0x00 when fill hits 0 exactly.
//  i_len==0 with i_valid: accepted, adds no bits; legal carrier for i_last.
//  Zero pending bits at i_last with EOI disabled: no byte, no o_data_end.
//   Upstream guarantees each scan has >=1 bit.
//  i_wait high: state, fill and o_data hold; no byte is lost or duplicated.
//  rst mid-scan: all pending bits discarded; the next byte emitted is from new input.
// CONFIGURATION
//  JPEG_EOI_APPEND_EN
//   - Defined: after the pad/stuff bytes, emit 0xFF 0xD9; o_data_end on 0xD9.
//   - Undefined: EOI_FF/EOI_D9 states absent; scan ends on the pad/stuff byte.
// STRUCTURE
//  jpeg_pkg (shared) holds:
//   - packer_state_t enum {RUN,STUFF,PAD,STUFF_END,EOI_FF,EOI_D9}
//   - JPEG_MARKER_PREFIX=8'hFF, JPEG_EOI_CODE=8'hD9, JPEG_STUFF_BYTE=8'h00
//  Flat module; no sub-module warranted.
// TESTING
//  1. {code=3'b101 len3},{code=5'b10111 len5,last}, EOI off, i_wait=0
//     -> one byte 0xB7 with o_data_end.
//  2. {0xFF len8},{0x1 len1,last}, EOI off
//     -> 0xFF, 0x00, 0xFF(pad), 0x00 with o_data_end on final 0x00.
//  3. Same as 1 with JPEG_EOI_APPEND_EN
//     -> 0xB7, 0xFF, 0xD9; o_data_end only on 0xD9.
//  4. Stream 1000 random codes while i_wait toggles every 3 cycles
//     -> golden byte stream matches exactly; o_valid never high with i_wait high.
//  5. Burst of 32-bit codes
//     -> o_ready drops when fill>32, recovers after pops; no bit lost.
//  6. rst asserted mid-scan with fill=13, then {0xA len4},{0x5 len4,last}
//     -> single 0xA5 with o_data_end.

Source files
------------

// File: rtl/jpeg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jpeg_pkg : shared types and marker constants for the JPEG scan datapath    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package jpeg_pkg;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    STUFF     = 3'd1,
    PAD       = 3'd2,
    STUFF_END = 3'd3,
    EOI_FF    = 3'd4,
    EOI_D9    = 3'd5
  } packer_state_t;

  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] JPEG_EOI_CODE      = 8'hD9;
  localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;

endpackage : jpeg_pkg
`default_nettype wire

// File: rtl/jpeg_bit_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jpeg_bit_packer : MSB-first codeword packer with 0xFF byte stuffing,       |
// |                   1-padding of the final byte and optional EOI marker.     |
// | Option   : JPEG_EOI_APPEND_EN appends 0xFF 0xD9 after each scan.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module jpeg_bit_packer
  import jpeg_pkg::*;
#(
  parameter int MAX_CODE_LEN = 32,
  parameter int BUF_W        = 64,
  localparam int LEN_W       = $clog2(MAX_CODE_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MAX_CODE_LEN-1:0] i_code,
  input  logic [LEN_W-1:0]        i_len,
  input  logic                    i_valid,
  input  logic                    i_last,
  output logic                    o_ready,
  output logic [7:0]              o_data,
  output logic                    o_valid,
  output logic                    o_data_end,
  input  logic                    i_wait
);

  localparam int FILL_W = $clog2(BUF_W + 1);

`ifdef JPEG_EOI_APPEND_EN
  localparam packer_state_t C_END_STATE = EOI_FF;
  localparam logic          C_END_KEEP  = 1'b1;
`else
  localparam packer_state_t C_END_STATE = RUN;
  localparam logic          C_END_KEEP  = 1'b0;
`endif

  // Valid bits are left-aligned: the oldest bit sits at r_buf[BUF_W-1].
  packer_state_t     r_state;
  logic [BUF_W-1:0]  r_buf;
  logic [FILL_W-1:0] r_fill;
  logic              r_last_seen;

  logic [LEN_W-1:0]  w_len;
  logic [7:0]        w_top;
  logic [7:0]        w_pad_byte;
  logic              w_accept;
  logic              w_pop;
  logic [FILL_W-1:0] w_fill_mid;
  logic [FILL_W-1:0] w_ins_sh;
  logic [BUF_W-1:0]  w_mask;
  logic [BUF_W-1:0]  w_code_ext;
  logic [BUF_W-1:0]  w_buf_next_run;
  logic [FILL_W-1:0] w_fill_next_run;
  logic              w_last_now;
  logic              w_end_on_pop;
  logic              w_pending;
  logic              w_end_cond;

  assign w_len      = (i_len > LEN_W'(MAX_CODE_LEN)) ? LEN_W'(MAX_CODE_LEN) : i_len;
  assign w_top      = r_buf[BUF_W-1 -: 8];
  assign w_pad_byte = w_top | (8'hFF >> r_fill);

  assign o_ready  = (r_state == RUN) & ~r_last_seen & (r_fill <= FILL_W'(BUF_W - MAX_CODE_LEN));
  assign w_accept = i_valid & o_ready;
  assign w_pop    = (r_state == RUN) & (r_fill >= FILL_W'(8)) & ~i_wait;

  // Pop first, then append the new codeword directly below the surviving bits.
  assign w_fill_mid      = w_pop ? (r_fill - FILL_W'(8)) : r_fill;
  assign w_ins_sh        = FILL_W'(BUF_W) - w_fill_mid - FILL_W'(w_len);
  assign w_mask          = ~({BUF_W{1'b1}} << w_len);
  assign w_code_ext      = {{(BUF_W - MAX_CODE_LEN){1'b0}}, i_code} & w_mask;
  assign w_buf_next_run  = (w_pop ? (r_buf << 8) : r_buf) |
                           (w_accept ? (w_code_ext << w_ins_sh) : '0);
  assign w_fill_next_run = w_fill_mid + (w_accept ? FILL_W'(w_len) : '0);
  assign w_last_now      = r_last_seen | (w_accept & i_last);

  // A zero-length i_last arriving while exactly one byte is buffered ends the scan on that byte.
  assign w_end_on_pop = (r_fill == FILL_W'(8)) & (w_top != JPEG_MARKER_PREFIX) &
                        (r_last_seen | (w_accept & i_last & (w_len == '0)));

  always_comb begin
    w_pending = 1'b1;
    o_data    = JPEG_STUFF_BYTE;
    case (r_state)
      RUN: begin
        w_pending = (r_fill >= FILL_W'(8));
        o_data    = w_top;
      end
      PAD:     o_data = w_pad_byte;
      EOI_FF:  o_data = JPEG_MARKER_PREFIX;
      EOI_D9:  o_data = JPEG_EOI_CODE;
      default: o_data = JPEG_STUFF_BYTE;
    endcase
  end

  always_comb begin
    w_end_cond = 1'b0;
`ifdef JPEG_EOI_APPEND_EN
    w_end_cond = (r_state == EOI_D9);
`else
    case (r_state)
      RUN:       w_end_cond = w_end_on_pop;
      STUFF:     w_end_cond = r_last_seen & (r_fill == '0);
      PAD:       w_end_cond = (w_pad_byte != JPEG_MARKER_PREFIX);
      STUFF_END: w_end_cond = 1'b1;
      default:   w_end_cond = 1'b0;
    endcase
`endif
  end

  assign o_valid    = w_pending & ~i_wait;
  assign o_data_end = o_valid & w_end_cond;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_buf       <= '0;
      r_fill      <= '0;
      r_last_seen <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_buf       <= w_buf_next_run;
          r_fill      <= w_fill_next_run;
          r_last_seen <= w_last_now;
          if (w_pop && (w_top == JPEG_MARKER_PREFIX)) begin
            r_state <= STUFF;
          end else if (r_last_seen && (r_fill < FILL_W'(8))) begin
            if (r_fill != '0) begin
              r_state <= PAD;
            end else begin
              r_state     <= C_END_STATE;
              r_last_seen <= C_END_KEEP;
            end
          end
        end
        STUFF: begin
          if (!i_wait) r_state <= RUN;
        end
        PAD: begin
          if (!i_wait) begin
            r_buf  <= '0;
            r_fill <= '0;
            if (w_pad_byte == JPEG_MARKER_PREFIX) begin
              r_state <= STUFF_END;
            end else begin
              r_state     <= C_END_STATE;
              r_last_seen <= C_END_KEEP;
            end
          end
        end
        STUFF_END: begin
          if (!i_wait) begin
            r_state     <= C_END_STATE;
            r_last_seen <= C_END_KEEP;
          end
        end
`ifdef JPEG_EOI_APPEND_EN
        EOI_FF: begin
          if (!i_wait) r_state <= EOI_D9;
        end
        EOI_D9: begin
          if (!i_wait) begin
            r_state     <= RUN;
            r_last_seen <= 1'b0;
          end
        end
`endif
        default: r_state <= RUN;
      endcase
    end
  end

endmodule : jpeg_bit_packer
`default_nettype wire
